// File: rtl/car_pkg.sv
// Shared definitions for the car display/drive blocks.
//   drive_state_t : drive FSM states (ST_IDLE, ST_RUN)
//   DISP_ODO/TRIP : disp_sel encodings for the 7-seg source mux
//   bcd_digit_t   : one packed BCD digit
//   bcd_digit_inc : single-digit BCD increment (9 wraps to 0)
package car_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } drive_state_t;

  localparam logic DISP_ODO  = 1'b0;
  localparam logic DISP_TRIP = 1'b1;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_digit_inc(input bcd_digit_t d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Cascaded packed-BCD up counter.
//   clk    : system clock
//   rst    : asynchronous active-low reset (value -> 0)
//   inc    : count up by one this cycle
//   clr    : synchronous clear, wins over inc
//   value  : packed BCD, most significant digit in the highest nibble
//   at_max : all digits are 9
// At all-9s an increment wraps to all-0s, or holds when SATURATE=1.
module bcd_counter
  import car_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic                  at_max
);

  logic [4*DIGITS-1:0] value_q;
  logic [4*DIGITS-1:0] inc_value;
  logic                all_nine;
  logic                carry;
  bcd_digit_t          digit;

  // Ripple the +1 through the digits; a digit only moves when every lower
  // digit was 9, so an all-9s value naturally rolls over to all-0s.
  always_comb begin
    carry     = 1'b1;
    all_nine  = 1'b1;
    inc_value = value_q;
    digit     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd_digit_t'(value_q[4*i +: 4]);
      if (digit != BCD_MAX) begin
        all_nine = 1'b0;
      end
      if (carry) begin
        inc_value[4*i +: 4] = bcd_digit_inc(digit);
        carry               = (digit == BCD_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else if (clr) begin
      value_q <= '0;
    end else if (inc) begin
      if (!(all_nine && SATURATE)) begin
        value_q <= inc_value;
      end
    end
  end

  assign value  = value_q;
  assign at_max = all_nine;

endmodule

// File: rtl/odometer_trip.sv
// Distance meter: integrates a speed code into distance units and keeps a
// non-clearing odometer plus a clearable trip counter, both packed BCD.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   run        : drive mode active
//   speed      : distance increments per integration tick (0 = stopped)
//   trip_clr   : synchronous trip clear (pulse or level)
//   disp_sel   : 0 shows odometer on disp_bcd, 1 shows trip
//   odo_bcd    : odometer, packed BCD
//   trip_bcd   : trip counter, packed BCD
//   disp_bcd   : registered copy of the selected counter for the 7-seg scanner
//   unit_pulse : one-cycle strobe per distance unit, aligned with counter update
//   odo_wrap   : sticky, set when the odometer is bumped while at all-9s
//   running    : drive FSM is in RUN
module odometer_trip
  import car_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int SPD_W       = 2,
  parameter int UNIT_THRESH = 500,
  parameter int DIGITS      = 3,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [SPD_W-1:0]    speed,
  input  logic                trip_clr,
  input  logic                disp_sel,
  output logic [4*DIGITS-1:0] odo_bcd,
  output logic [4*DIGITS-1:0] trip_bcd,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic                unit_pulse,
  output logic                odo_wrap,
  output logic                running
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Sized so that acc (< UNIT_THRESH) plus the largest speed never overflows.
  localparam int ACC_W   = $clog2(UNIT_THRESH + 2**SPD_W);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [ACC_W-1:0]   THRESH     = ACC_W'(UNIT_THRESH);

  drive_state_t        state_q;
  drive_state_t        state_d;
  logic [PRESC_W-1:0]  presc_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_next;
  logic                counting;
  logic                tick;
  logic                unit_inc;
  logic                odo_at_max;

  // Drive FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drive FSM next state: simply follows run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run)  state_d = ST_RUN;
      ST_RUN:  if (!run) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Integration only happens while in RUN with run still asserted; the cycle
  // run drops gets no tick, so a partial accumulation is thrown away rather
  // than producing a late unit. Using >= lets any speed cross the threshold.
  always_comb begin
    counting = (state_q == ST_RUN) && run;
    tick     = counting && (presc_q == PRESC_LAST);
    acc_next = acc_q + ACC_W'(speed);
    unit_inc = tick && (acc_next >= THRESH);
  end

  // Prescaler and accumulator; both sit at zero whenever not counting, which
  // is what clears them on the way back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      acc_q   <= '0;
    end else if (!counting) begin
      presc_q <= '0;
      acc_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        acc_q <= unit_inc ? acc_next - THRESH : acc_next;
      end
    end
  end

  bcd_counter #(
    .DIGITS   (DIGITS),
    .SATURATE (SATURATE)
  ) u_odo (
    .clk    (clk),
    .rst    (rst),
    .inc    (unit_inc),
    .clr    (1'b0),
    .value  (odo_bcd),
    .at_max (odo_at_max)
  );

  // Trip rolls over silently, so its at_max has no consumer.
  bcd_counter #(
    .DIGITS   (DIGITS),
    .SATURATE (1'b0)
  ) u_trip (
    .clk    (clk),
    .rst    (rst),
    .inc    (unit_inc),
    .clr    (trip_clr),
    .value  (trip_bcd),
    .at_max ()
  );

  // Registered outputs: unit strobe lines up with the counter update, the
  // wrap flag is sticky until reset, and the display copy lags one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_pulse <= 1'b0;
      odo_wrap   <= 1'b0;
      disp_bcd   <= '0;
    end else begin
      unit_pulse <= unit_inc;
      if (unit_inc && odo_at_max) begin
        odo_wrap <= 1'b1;
      end
      disp_bcd <= (disp_sel == DISP_TRIP) ? trip_bcd : odo_bcd;
    end
  end

  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_odometer_trip.sv
module tb_odometer_trip;

  localparam int TICK_DIV    = 4;
  localparam int SPD_W       = 2;
  localparam int UNIT_THRESH = 10;
  localparam int DIGITS      = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [SPD_W-1:0] speed;
  logic             trip_clr;
  logic             disp_sel;

  logic [11:0] odo_bcd, trip_bcd, disp_bcd;
  logic        unit_pulse, odo_wrap, running;
  logic [11:0] s_odo_bcd, s_trip_bcd, s_disp_bcd;
  logic        s_unit_pulse, s_odo_wrap, s_running;

  int checks    = 0;
  int passes    = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  odometer_trip #(
    .TICK_DIV(TICK_DIV), .SPD_W(SPD_W), .UNIT_THRESH(UNIT_THRESH),
    .DIGITS(DIGITS), .SATURATE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .speed(speed), .trip_clr(trip_clr),
    .disp_sel(disp_sel), .odo_bcd(odo_bcd), .trip_bcd(trip_bcd),
    .disp_bcd(disp_bcd), .unit_pulse(unit_pulse), .odo_wrap(odo_wrap),
    .running(running)
  );

  odometer_trip #(
    .TICK_DIV(TICK_DIV), .SPD_W(SPD_W), .UNIT_THRESH(UNIT_THRESH),
    .DIGITS(DIGITS), .SATURATE(1'b1)
  ) dut_sat (
    .clk(clk), .rst(rst), .run(run), .speed(speed), .trip_clr(trip_clr),
    .disp_sel(disp_sel), .odo_bcd(s_odo_bcd), .trip_bcd(s_trip_bcd),
    .disp_bcd(s_disp_bcd), .unit_pulse(s_unit_pulse), .odo_wrap(s_odo_wrap),
    .running(s_running)
  );

  // Advance n clocks, sampling on the falling edge and counting unit strobes.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (unit_pulse) pulse_cnt++;
    end
  endtask

  // Run until n unit strobes are seen, bounded by a cycle budget.
  task automatic wait_units(input int n, input int budget);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (unit_pulse) seen++;
    end
    checks++;
    if (seen < n) $display("[TB] FAIL wait_units: got %0d units want %0d", seen, n);
    else passes++;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (odo_bcd !== 12'h000) $display("[TB] FAIL reset_odo: got %h want 000", odo_bcd); else passes++;
    checks++; if (trip_bcd !== 12'h000) $display("[TB] FAIL reset_trip: got %h want 000", trip_bcd); else passes++;
    checks++; if (disp_bcd !== 12'h000) $display("[TB] FAIL reset_disp: got %h want 000", disp_bcd); else passes++;
    checks++; if (unit_pulse !== 1'b0) $display("[TB] FAIL reset_pulse: got %b want 0", unit_pulse); else passes++;
    checks++; if (odo_wrap !== 1'b0) $display("[TB] FAIL reset_wrap: got %b want 0", odo_wrap); else passes++;
    checks++; if (running !== 1'b0) $display("[TB] FAIL reset_running: got %b want 0", running); else passes++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // 40 ticks at speed 3: 120 increments = 12 units exactly.
  task automatic test_forty_ticks();
    pulse_cnt = 0;
    speed = 2'd3;
    run   = 1'b1;
    step(161);
    checks++; if (running !== 1'b1) $display("[TB] FAIL run_running: got %b want 1", running); else passes++;
    checks++; if (pulse_cnt != 12) $display("[TB] FAIL run_pulses: got %0d want 12", pulse_cnt); else passes++;
    checks++; if (odo_bcd !== 12'h012) $display("[TB] FAIL run_odo: got %h want 012", odo_bcd); else passes++;
    checks++; if (trip_bcd !== 12'h012) $display("[TB] FAIL run_trip: got %h want 012", trip_bcd); else passes++;
    run = 1'b0;
    step(1);
    checks++; if (running !== 1'b0) $display("[TB] FAIL stop_running: got %b want 0", running); else passes++;
    checks++; if (disp_bcd !== 12'h012) $display("[TB] FAIL run_disp: got %h want 012", disp_bcd); else passes++;
  endtask

  // acc reaches 9 after 3 ticks; 4th tick at speed 3 gives 12 -> unit, acc 2.
  // Then speed 1 needs 8 more ticks for the next unit.
  task automatic test_no_skip();
    pulse_cnt = 0;
    speed = 2'd3;
    run   = 1'b1;
    step(16);
    checks++; if (pulse_cnt != 0) $display("[TB] FAIL noskip_early: got %0d pulses want 0", pulse_cnt); else passes++;
    step(1);
    checks++; if (unit_pulse !== 1'b1) $display("[TB] FAIL noskip_pulse: got %b want 1", unit_pulse); else passes++;
    checks++; if (odo_bcd !== 12'h013) $display("[TB] FAIL noskip_odo: got %h want 013", odo_bcd); else passes++;
    speed = 2'd1;
    step(31);
    checks++; if (pulse_cnt != 1) $display("[TB] FAIL noskip_remainder: got %0d pulses want 1", pulse_cnt); else passes++;
    step(1);
    checks++; if (unit_pulse !== 1'b1) $display("[TB] FAIL noskip_pulse2: got %b want 1", unit_pulse); else passes++;
    checks++; if (odo_bcd !== 12'h014) $display("[TB] FAIL noskip_odo2: got %h want 014", odo_bcd); else passes++;
    run = 1'b0;
    step(2);
  endtask

  // acc=7 is discarded on leaving RUN; restart at speed 1 needs 10 ticks.
  task automatic test_run_drop();
    pulse_cnt = 0;
    speed = 2'd1;
    run   = 1'b1;
    step(30);
    run = 1'b0;
    step(3);
    checks++; if (running !== 1'b0) $display("[TB] FAIL drop_running: got %b want 0", running); else passes++;
    run = 1'b1;
    step(40);
    checks++; if (pulse_cnt != 0) $display("[TB] FAIL drop_pulses: got %0d want 0", pulse_cnt); else passes++;
    checks++; if (odo_bcd !== 12'h014) $display("[TB] FAIL drop_odo_hold: got %h want 014", odo_bcd); else passes++;
    step(1);
    checks++; if (unit_pulse !== 1'b1) $display("[TB] FAIL drop_pulse: got %b want 1", unit_pulse); else passes++;
    checks++; if (odo_bcd !== 12'h015) $display("[TB] FAIL drop_odo: got %h want 015", odo_bcd); else passes++;
    run = 1'b0;
    step(2);
  endtask

  // trip_clr lands on the cycle of the first unit (4th tick at speed 3).
  task automatic test_trip_clr();
    checks++; if (trip_bcd !== 12'h015) $display("[TB] FAIL clr_trip_before: got %h want 015", trip_bcd); else passes++;
    pulse_cnt = 0;
    speed = 2'd3;
    run   = 1'b1;
    step(16);
    trip_clr = 1'b1;
    step(1);
    trip_clr = 1'b0;
    disp_sel = 1'b1;
    checks++; if (unit_pulse !== 1'b1) $display("[TB] FAIL clr_pulse: got %b want 1", unit_pulse); else passes++;
    checks++; if (trip_bcd !== 12'h000) $display("[TB] FAIL clr_trip: got %h want 000", trip_bcd); else passes++;
    checks++; if (odo_bcd !== 12'h016) $display("[TB] FAIL clr_odo: got %h want 016", odo_bcd); else passes++;
    step(1);
    checks++; if (disp_bcd !== 12'h000) $display("[TB] FAIL clr_disp: got %h want 000", disp_bcd); else passes++;
    step(11);
    checks++; if (trip_bcd !== 12'h001) $display("[TB] FAIL clr_trip_next: got %h want 001", trip_bcd); else passes++;
    checks++; if (odo_bcd !== 12'h017) $display("[TB] FAIL clr_odo_next: got %h want 017", odo_bcd); else passes++;
    step(1);
    checks++; if (disp_bcd !== 12'h001) $display("[TB] FAIL clr_disp_next: got %h want 001", disp_bcd); else passes++;
    run      = 1'b0;
    disp_sel = 1'b0;
    step(2);
    checks++; if (disp_bcd !== 12'h017) $display("[TB] FAIL disp_back_odo: got %h want 017", disp_bcd); else passes++;
  endtask

  // 017 + 982 = 999; next unit wraps (SATURATE=0) or holds (SATURATE=1).
  task automatic test_wrap();
    speed = 2'd3;
    run   = 1'b1;
    wait_units(982, 20000);
    checks++; if (odo_bcd !== 12'h999) $display("[TB] FAIL wrap_odo_max: got %h want 999", odo_bcd); else passes++;
    checks++; if (s_odo_bcd !== 12'h999) $display("[TB] FAIL sat_odo_max: got %h want 999", s_odo_bcd); else passes++;
    checks++; if (odo_wrap !== 1'b0) $display("[TB] FAIL wrap_flag_early: got %b want 0", odo_wrap); else passes++;
    wait_units(1, 100);
    checks++; if (odo_bcd !== 12'h000) $display("[TB] FAIL wrap_odo: got %h want 000", odo_bcd); else passes++;
    checks++; if (odo_wrap !== 1'b1) $display("[TB] FAIL wrap_flag: got %b want 1", odo_wrap); else passes++;
    checks++; if (s_odo_bcd !== 12'h999) $display("[TB] FAIL sat_odo_hold: got %h want 999", s_odo_bcd); else passes++;
    checks++; if (s_odo_wrap !== 1'b1) $display("[TB] FAIL sat_flag: got %b want 1", s_odo_wrap); else passes++;
    checks++; if (trip_bcd !== 12'h984) $display("[TB] FAIL wrap_trip: got %h want 984", trip_bcd); else passes++;
    wait_units(1, 100);
    checks++; if (odo_bcd !== 12'h001) $display("[TB] FAIL wrap_odo_after: got %h want 001", odo_bcd); else passes++;
    checks++; if (odo_wrap !== 1'b1) $display("[TB] FAIL wrap_sticky: got %b want 1", odo_wrap); else passes++;
    checks++; if (s_odo_bcd !== 12'h999) $display("[TB] FAIL sat_odo_hold2: got %h want 999", s_odo_bcd); else passes++;
    run = 1'b0;
    step(2);
  endtask

  // Count up to 007, then assert reset between clock edges.
  task automatic test_reset_mid_count();
    speed = 2'd3;
    run   = 1'b1;
    wait_units(6, 200);
    checks++; if (odo_bcd !== 12'h007) $display("[TB] FAIL mid_odo_pre: got %h want 007", odo_bcd); else passes++;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (odo_bcd !== 12'h000) $display("[TB] FAIL mid_odo: got %h want 000", odo_bcd); else passes++;
    checks++; if (trip_bcd !== 12'h000) $display("[TB] FAIL mid_trip: got %h want 000", trip_bcd); else passes++;
    checks++; if (disp_bcd !== 12'h000) $display("[TB] FAIL mid_disp: got %h want 000", disp_bcd); else passes++;
    checks++; if (odo_wrap !== 1'b0) $display("[TB] FAIL mid_wrap: got %b want 0", odo_wrap); else passes++;
    checks++; if (running !== 1'b0) $display("[TB] FAIL mid_running: got %b want 0", running); else passes++;
    checks++; if (s_odo_bcd !== 12'h000) $display("[TB] FAIL mid_sat_odo: got %h want 000", s_odo_bcd); else passes++;
    checks++; if (s_odo_wrap !== 1'b0) $display("[TB] FAIL mid_sat_wrap: got %b want 0", s_odo_wrap); else passes++;
    @(negedge clk);
    run = 1'b0;
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    rst      = 1'b0;
    run      = 1'b0;
    speed    = '0;
    trip_clr = 1'b0;
    disp_sel = 1'b0;
    test_reset();
    test_forty_ticks();
    test_no_skip();
    test_run_drop();
    test_trip_clr();
    test_wrap();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
